// File: rtl/cnn_mem_pkg.sv
// Shared types, default geometry and range helper for the CNN layer result buffer.
// Default geometry follows the LAYER5_OUTPUT_LENGTH / LAYER6_INPUT_ROWS / LAYER6_INPUT_COLS macros when present.
`ifndef LAYER5_OUTPUT_LENGTH
`define LAYER5_OUTPUT_LENGTH 128
`endif
`ifndef LAYER6_INPUT_ROWS
`define LAYER6_INPUT_ROWS 5
`endif
`ifndef LAYER6_INPUT_COLS
`define LAYER6_INPUT_COLS 5
`endif

package cnn_mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } mem_state_e;

  localparam int DEF_DATA_W = `LAYER5_OUTPUT_LENGTH;
  localparam int DEF_ROWS   = `LAYER6_INPUT_ROWS;
  localparam int DEF_COLS   = `LAYER6_INPUT_COLS;

  function automatic logic idx_in_range(input int unsigned row, input int unsigned col,
                                        input int unsigned rows, input int unsigned cols);
    return (row < rows) && (col < cols);
  endfunction

endpackage

// File: rtl/cnn_bank_plane.sv
// One bank of the result buffer: word array, per-entry written flags, fill counter.
// With CNN_RESULT_MEM_BYPASS_EN defined, a same-entry write is forwarded to the read.
module cnn_bank_plane
  import cnn_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  localparam int N     = ROWS * COLS,
  localparam int IW    = (N > 1) ? $clog2(N) : 1,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cnt_clr,
  input  logic              clr,
  input  logic [RW-1:0]     clr_row,
  input  logic              wr,
  input  logic [IW-1:0]     wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_vld,
  input  logic              rd_ok,
  input  logic [IW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full
);

  localparam int CW = $clog2(N + 1);

  logic [DATA_W-1:0] mem_q [N];
  logic [N-1:0]      flag_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_word;

  // Contents are masked by the flags, so the array itself carries no reset.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int c = 0; c < COLS; c++)
        mem_q[IW'(32'(clr_row) * 32'(COLS) + 32'(c))] <= '0;
    end else if (wr) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= '0;
    end else if (clr) begin
      for (int c = 0; c < COLS; c++)
        flag_q[IW'(32'(clr_row) * 32'(COLS) + 32'(c))] <= 1'b0;
    end else if (wr) begin
      flag_q[wr_idx] <= 1'b1;
    end
  end

  // Only first writes to an entry advance the count, so it cannot pass N.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (cnt_clr)
      cnt_q <= '0;
    else if (wr && !flag_q[wr_idx])
      cnt_q <= cnt_q + CW'(1);
  end

  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      if (flag_q[rd_idx])
        rd_word = mem_q[rd_idx];
`ifdef CNN_RESULT_MEM_BYPASS_EN
      if (wr && (wr_idx == rd_idx))
        rd_word = wr_data;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_word;
      rd_valid_q <= rd_vld;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign full     = (cnt_q == CW'(N));

endmodule

// File: rtl/cnn_layer_result_bank_mem.sv
// Multi-bank CNN layer result buffer: shared write port, per-bank registered reads, clear sweep.
// Optional write-to-read forwarding is enabled by defining CNN_RESULT_MEM_BYPASS_EN.
module cnn_layer_result_bank_mem
  import cnn_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int BANKS  = 2,
  parameter int ADDR_W = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       clear_req,
  output logic                                       busy,
  input  logic                                       wr_en,
  input  logic [((BANKS > 1) ? $clog2(BANKS) : 1)-1:0] wr_bank,
  input  logic [ADDR_W-1:0]                          wr_row,
  input  logic [ADDR_W-1:0]                          wr_col,
  input  logic [DATA_W-1:0]                          wr_data,
  input  logic [BANKS-1:0]                           rd_en,
  input  logic [ADDR_W-1:0]                          rd_row,
  input  logic [ADDR_W-1:0]                          rd_col,
  output logic [BANKS*DATA_W-1:0]                    rd_data,
  output logic [BANKS-1:0]                           rd_valid,
  output logic [BANKS-1:0]                           bank_full,
  output logic                                       addr_err
);

  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;

  mem_state_e    state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic          err_q, err_d;
  logic          wr_ok, wr_go, rd_in, clr_start;
  logic [IW-1:0] wr_idx, rd_idx;

  assign busy      = (state_q == CLEAR);
  assign clr_start = (state_q == IDLE) && clear_req;
  assign wr_ok     = idx_in_range(32'(wr_row), 32'(wr_col), ROWS, COLS) && (32'(wr_bank) < 32'(BANKS));
  assign rd_in     = idx_in_range(32'(rd_row), 32'(rd_col), ROWS, COLS);
  assign wr_go     = wr_en && !busy && wr_ok;
  assign wr_idx    = IW'(32'(wr_row) * 32'(COLS) + 32'(wr_col));
  assign rd_idx    = IW'(32'(rd_row) * 32'(COLS) + 32'(rd_col));
  // Errors from both ports in the same cycle fold into one pulse.
  assign err_d     = !busy && ((wr_en && !wr_ok) || ((|rd_en) && !rd_in));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          row_d   = '0;
        end
      end
      CLEAR: begin
        if (row_q == RW'(ROWS - 1))
          state_d = IDLE;
        else
          row_d = row_q + RW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      err_q   <= err_d;
    end
  end

  assign addr_err = err_q;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    cnn_bank_plane #(
      .DATA_W (DATA_W),
      .ROWS   (ROWS),
      .COLS   (COLS)
    ) u_plane (
      .clk      (clk),
      .rst      (rst),
      .cnt_clr  (clr_start),
      .clr      (busy),
      .clr_row  (row_q),
      .wr       (wr_go && (wr_bank == BW'(b))),
      .wr_idx   (wr_idx),
      .wr_data  (wr_data),
      .rd_vld   (rd_en[b] && !busy),
      .rd_ok    (rd_en[b] && !busy && rd_in),
      .rd_idx   (rd_idx),
      .rd_data  (rd_data[b*DATA_W +: DATA_W]),
      .rd_valid (rd_valid[b]),
      .full     (bank_full[b])
    );
  end

endmodule

// File: doc/cnn_layer_result_bank_mem.md
Name: cnn_layer_result_bank_mem

Overview:
- Parametrised on-chip result buffer for CNN layer outputs (layer5/layer6 style).
- Holds BANKS independent ROWS x COLS planes of DATA_W-bit words.
- One shared write port with a bank select; one read port per bank, all sharing one read address.
- Adds over the previous fixed two-side buffer: registered reads with valid strobes, per-entry written flags, per-bank fill counters and full flags, a swept clear state machine, and address-range error reporting.

Parameters:
- DATA_W, 128, word width in bits (LAYER5_OUTPUT_LENGTH by default).
- ROWS, 5, rows per bank plane.
- COLS, 5, columns per bank plane.
- BANKS, 2, number of independent planes (the "sides").
- ADDR_W, 16, width of the row and column address inputs.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clear_req  in  1  pulse; starts the clear sweep
- busy  out  1  high while the clear sweep runs
- wr_en  in  1  write strobe
- wr_bank  in  $clog2(BANKS)  target bank
- wr_row  in  ADDR_W  write row
- wr_col  in  ADDR_W  write column
- wr_data  in  DATA_W  write word
- rd_en  in  BANKS  per-bank read request
- rd_row  in  ADDR_W  read row, shared by all banks
- rd_col  in  ADDR_W  read column, shared by all banks
- rd_data  out  BANKS*DATA_W  read words; bank b occupies bits [b*DATA_W +: DATA_W]
- rd_valid  out  BANKS  read data valid, one cycle after rd_en
- bank_full  out  BANKS  every entry of the bank has been written since the last clear
- addr_err  out  1  one-cycle pulse on an out-of-range write or read

Behaviour:
- Reset:
  - All written flags, fill counters, rd_data, rd_valid, addr_err and busy go to 0.
  - FSM goes to IDLE.
  - Data array contents are don't-care; the written flags mask them.
- Write:
  - Accepted at posedge when wr_en=1, busy=0, wr_row<ROWS, wr_col<COLS and wr_bank<BANKS.
  - Stores wr_data and sets the entry's written flag.
  - The bank's fill_cnt increments only if the flag was previously 0, so rewrites do not count.
- Read:
  - Issued at posedge when rd_en[b]=1, busy=0 and the address is in range.
  - rd_data[b] and rd_valid[b] register at that same edge, giving 1-cycle latency.
  - rd_data[b] is the stored word if the written flag is set, otherwise 0.
  - In any cycle with rd_en[b]=0, rd_valid[b]=0 and rd_data[b] is forced to 0.
- Read/write same entry, same cycle: read-first; the old value is returned.
- Out-of-range access:
  - The write is dropped, or the read returns rd_valid[b]=1 with rd_data[b]=0.
  - addr_err pulses 1 cycle after the edge.
  - Multiple simultaneous errors produce a single pulse.
- bank_full[b] = (fill_cnt[b] == ROWS*COLS).
  - fill_cnt is $clog2(ROWS*COLS+1) bits wide and saturates by construction.
- FSM:
  - IDLE -> CLEAR on clear_req=1.
  - CLEAR: row_ptr sweeps 0..ROWS-1, one row per cycle.
  - Each cycle, all COLS entries of all banks in that row are zeroed and their flags cleared.
  - The CLEAR -> IDLE transition happens after row ROWS-1.
  - busy=1 for exactly ROWS cycles.
  - Fill counters reset to 0 on entry to CLEAR.
  - clear_req while in CLEAR is ignored.
- Accesses while busy:
  - wr_en and rd_en are ignored; no addr_err is raised.
  - rd_valid stays 0.
- Simultaneous clear_req and wr_en in IDLE: the write completes, then the clear sweep erases it.
- Reset mid-sweep: the sweep aborts immediately, FSM returns to IDLE, all flags and counters are 0.

Optional Feature:
- Macro: CNN_RESULT_MEM_BYPASS_EN.
- Defined: same-cycle read/write to the same bank/row/col forwards wr_data (write-first) and counts as written.
- Undefined: read-first behaviour as above.

Decomposition:
- Shared package cnn_mem_pkg holds:
  - mem_state_e (IDLE, CLEAR).
  - Default DATA_W/ROWS/COLS constants tied to the LAYERx_* macros.
  - Function idx_in_range(row, col, rows, cols).
- Sub-module cnn_bank_plane: one bank's array, flags and fill counter, instantiated BANKS times.
- The top level owns the FSM, address checks and error pulse.

Test Plan:
- Reset, then read bank0 (2,3) -> rd_valid=01, rd_data=0, one cycle after rd_en.
- Write 0xA5 to bank1 (4,4); read both banks at (4,4) -> rd_data bank1=0xA5, bank0=0, rd_valid=11.
- Write all 25 entries of bank0, rewrite (0,0) -> bank_full=01 after the 25th write; fill_cnt stays 25 after the rewrite.
- Write to (5,0) -> write dropped, addr_err pulses 1 cycle; a subsequent read of (0,0) is unchanged.
- clear_req with bank0 full -> busy high 5 cycles; bank_full=00; rd_en during busy gives rd_valid=0; later reads return 0.
- Same-cycle write 0x11 and read at bank0 (1,1) holding 0x22 -> returns 0x22; with CNN_RESULT_MEM_BYPASS_EN returns 0x11.
